imem_loader: RTL
================

# imem_loader

Boot-time program loader: the write side of the instruction memory that the pipeline CPU fetches from. It accepts a byte stream over a valid/ready handshake. The stream is a 4-byte word-count header followed by that many 32-bit instruction words. Each assembled word is written into the instruction memory write port at consecutive word addresses. The CPU is held in reset until the load completes cleanly.

## Interface
- BASE_ADDR, 32'd0: byte address of the first instruction written.
- MAX_WORDS, 256: largest legal word count in the header.
- clk_i  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start_i  input  1  one-cycle pulse that begins a load. Honoured only in IDLE, DONE and ERR.
- byte_valid_i  input  1  stream byte present.
- byte_data_i  input  8  stream byte.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- im_we_o  output  1  instruction memory write strobe.
- im_addr_o  output  32  instruction memory byte address.
- im_data_o  output  32  instruction word to write.
- cpu_rst_n_o  output  1  active-low reset for the CPU core.
- busy_o  output  1  high in HDR, LOAD and WRITE.
- done_o  output  1  load completed.
- err_o  output  1  header rejected.

## Operation
- Transfer rule: a byte is consumed only on a cycle where byte_valid_i && byte_ready_o. byte_valid_i while byte_ready_o=0 is not consumed, and the source must hold it.
- Bytes are packed big-endian. The first byte of a group goes to bits [31:24] and the fourth to bits [7:0]. A 2-bit byte counter tracks position and wraps 3→0.
- IDLE:
  - ready=0, cpu_rst_n_o=0.
  - start_i → HDR. Clears the byte counter, word index and shift register.
- HDR:
  - ready=1.
  - On the 4th consumed byte, count := assembled word. Next state:
    - count == 0 → DONE.
    - count > MAX_WORDS → ERR.
    - otherwise → LOAD.
- LOAD:
  - ready=1.
  - On the 4th consumed byte of a word → WRITE.
- WRITE (exactly one cycle):
  - ready=0, im_we_o=1.
  - im_addr_o = BASE_ADDR + (idx << 2), modulo 2^32.
  - im_data_o = assembled word.
  - Then idx := idx+1. Go to DONE if idx+1 == count, else LOAD.
- DONE:
  - done_o=1, cpu_rst_n_o=1, ready=0.
  - start_i → HDR. cpu_rst_n_o drops to 0 in the same edge that enters HDR, and done_o clears.
- ERR:
  - err_o=1, cpu_rst_n_o=0, ready=0.
  - Left only via start_i → HDR, which clears err_o.
- start_i during HDR, LOAD or WRITE is ignored.
- Arithmetic widths:
  - count is stored at 32 bits; the comparison against MAX_WORDS is unsigned 32-bit.
  - idx is wide enough for MAX_WORDS, and idx+1 is compared at that width.

## Timing
- All outputs are registered.
- Reset values: byte_ready_o=0, im_we_o=0, im_addr_o=0, im_data_o=0, cpu_rst_n_o=0, busy_o=0, done_o=0, err_o=0. State=IDLE.
- rst_n low mid-load forces the reset values immediately (asynchronously):
  - the partial word is discarded;
  - no im_we_o pulse is produced after the reset assertion.
- Latency: the im_we_o pulse occurs in the cycle after the edge that consumes a word's 4th byte.
- Throughput: one word per 5 cycles with a back-to-back stream (4 transfer cycles plus 1 WRITE cycle).
- A full load of N words with a continuous stream takes 4 + 5N cycles from entering HDR to entering DONE.
- im_addr_o and im_data_o are stable through the WRITE cycle. Outside WRITE they hold their last values; they are not cleared.
- done_o, err_o and busy_o are mutually exclusive in every cycle.
- cpu_rst_n_o rises in the same edge as done_o.

## Test plan
- Basic load: reset, start_i, then stream 00 00 00 02, 20 08 00 05, 00 00 00 00 continuously.
  - Required: im_we_o pulses exactly twice: addr 0x0 / data 0x20080005, then addr 0x4 / data 0x00000000.
  - done_o=1 and cpu_rst_n_o=1 at cycle 14 after HDR is entered.
- Stalled source: same stream with byte_valid_i low on alternate cycles.
  - Required: identical writes and data; no byte lost or duplicated.
  - byte_ready_o=0 during both WRITE cycles.
- Header errors:
  - Header 0x00000101 with MAX_WORDS=256 → err_o=1, cpu_rst_n_o=0, no im_we_o.
  - Header 0 → done_o=1 with no writes.
- Reset mid-word: assert rst_n=0 after 2 bytes of word 1.
  - Required: all outputs return to reset values without waiting for a clock edge; no write occurs.
  - A fresh start_i and full stream then loads correctly from address BASE_ADDR.
- Reload and ignored start: pulse start_i in DONE.
  - Required: cpu_rst_n_o falls the same edge and a second stream of 1 word (0xAABBCCDD) is written to BASE_ADDR.
  - A start_i during LOAD is ignored: no counter reset, no address change.
- Address offset: BASE_ADDR=32'hFFFFFFFC with 2 words.
  - Required: writes go to 0xFFFFFFFC then wrap to 0x00000000.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a big-endian byte stream
// (word-count header + instruction words) into memory writes, then releases the CPU.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        im_we_o,
  output logic [31:0] im_addr_o,
  output logic [31:0] im_data_o,
  output logic        cpu_rst_n_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  // state   | meaning
  // S_IDLE  | after reset, waiting for start_i, CPU held in reset
  // S_HDR   | collecting the 4-byte word-count header
  // S_LOAD  | collecting the 4 bytes of the next instruction word
  // S_WRITE | single-cycle write of the assembled word
  // S_DONE  | load complete, CPU released
  // S_ERR   | header word count out of range, CPU held in reset
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD, S_WRITE, S_DONE, S_ERR
  } state_t;

  localparam int IW = $clog2(MAX_WORDS + 1);

  state_t          state;
  logic [1:0]      bcnt;
  logic [23:0]     shreg;
  logic [31:0]     count;
  logic [IW-1:0]   idx;

  logic            fire;
  logic [31:0]     word;
  logic [IW-1:0]   idx_inc;
  logic            last_word;
  logic [31:0]     word_addr;

  assign fire      = byte_valid_i && byte_ready_o;
  assign word      = {shreg, byte_data_i};
  assign idx_inc   = idx + 1'b1;
  assign last_word = (32'(idx_inc) == count);
  assign word_addr = BASE_ADDR + (32'(idx) << 2);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bcnt         <= 2'd0;
      shreg        <= 24'd0;
      count        <= 32'd0;
      idx          <= '0;
      byte_ready_o <= 1'b0;
      im_we_o      <= 1'b0;
      im_addr_o    <= 32'd0;
      im_data_o    <= 32'd0;
      cpu_rst_n_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      im_we_o <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state        <= S_HDR;
            bcnt         <= 2'd0;
            shreg        <= 24'd0;
            idx          <= '0;
            byte_ready_o <= 1'b1;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            cpu_rst_n_o  <= 1'b0;
          end
        end
        S_HDR: begin
          if (fire) begin
            bcnt  <= bcnt + 2'd1;
            shreg <= {shreg[15:0], byte_data_i};
            if (bcnt == 2'd3) begin
              count <= word;
              if (word == 32'd0) begin
                state        <= S_DONE;
                byte_ready_o <= 1'b0;
                busy_o       <= 1'b0;
                done_o       <= 1'b1;
                cpu_rst_n_o  <= 1'b1;
              end else if (word > 32'(MAX_WORDS)) begin
                state        <= S_ERR;
                byte_ready_o <= 1'b0;
                busy_o       <= 1'b0;
                err_o        <= 1'b1;
              end else begin
                state <= S_LOAD;
              end
            end
          end
        end
        S_LOAD: begin
          if (fire) begin
            bcnt  <= bcnt + 2'd1;
            shreg <= {shreg[15:0], byte_data_i};
            if (bcnt == 2'd3) begin
              state        <= S_WRITE;
              byte_ready_o <= 1'b0;
              im_we_o      <= 1'b1;
              im_addr_o    <= word_addr;
              im_data_o    <= word;
            end
          end
        end
        S_WRITE: begin
          idx <= idx_inc;
          if (last_word) begin
            state       <= S_DONE;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            cpu_rst_n_o <= 1'b1;
          end else begin
            state        <= S_LOAD;
            byte_ready_o <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
